// File: rtl/priority_en.sv
// priority_en - registered WIDTH-input priority encoder with enable.
//
// Each rising clock edge samples the request vector and loads the index of
// the highest-priority set bit into `out`, together with a `valid` flag.
// Latency is exactly one cycle. No combinational path runs from the inputs
// to the outputs.
//
// Parameters:
//   WIDTH    - number of request inputs (2..64)
//   MSB_PRIO - 1: bit WIDTH-1 wins, 0: bit 0 wins
//   OUT_W    - derived index width, $clog2(WIDTH)
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, overrides en
//   en    - encoder enable, sampled on the clock edge
//   in    - request vector, sampled on the clock edge
//   out   - registered index of the winning request bit
//   valid - registered flag, `out` holds a real winner
//   grant - (PRIORITY_EN_ONEHOT_EN only) registered one-hot winner mask
//
// Optional feature macro: PRIORITY_EN_ONEHOT_EN adds the `grant` output.

module priority_en #(
   parameter int  WIDTH    = 8,
   parameter int  MSB_PRIO = 1,
   localparam int OUT_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
`ifdef PRIORITY_EN_ONEHOT_EN
   output logic [WIDTH-1:0] grant,
`endif
   output logic [OUT_W-1:0] out,
   output logic             valid
);

   logic [OUT_W-1:0] win_idx;
   logic             any_req;
   logic [OUT_W-1:0] out_d, out_q;
   logic             valid_d, valid_q;

   // Scan so the highest-priority set bit is the last one written; later
   // assignments override earlier ones, which keeps the logic a simple chain.
   always_comb begin
      win_idx = '0;
      if (MSB_PRIO != 0) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) win_idx = OUT_W'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in[i]) win_idx = OUT_W'(i);
         end
      end
   end

   // Disabled or idle cycles load zeros; there is no hold-on-idle, every
   // non-reset edge reloads from the current inputs.
   always_comb begin
      any_req = |in;
      valid_d = en && any_req;
      out_d   = valid_d ? win_idx : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out   = out_q;
   assign valid = valid_q;

`ifdef PRIORITY_EN_ONEHOT_EN
   logic [WIDTH-1:0] grant_d, grant_q;

   // One-hot mask of the winner, all zeros whenever there is no winner.
   always_comb begin
      grant_d = '0;
      if (valid_d) grant_d[out_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= '0;
      end else begin
         grant_q <= grant_d;
      end
   end

   assign grant = grant_q;
`endif

endmodule

// File: tb/tb_priority_en.sv
// tb_priority_en - self-checking bench for priority_en.
//
// Two instances share clock and stimulus: one with MSB priority and one with
// LSB priority. Expected results come from a behavioural model, are pushed to
// a scoreboard queue when stimulus is driven and popped after the next edge.
// When PRIORITY_EN_ONEHOT_EN is defined the `grant` outputs are checked too.

module tb_priority_en;

   typedef struct packed {
      logic       valid_m;
      logic [2:0] out_m;
      logic       valid_l;
      logic [2:0] out_l;
      logic [7:0] grant_m;
      logic [7:0] grant_l;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_s = 1'b1;
   logic       en_s = 1'b0;
   logic [7:0] in_s = 8'h00;
   logic [2:0] out_m, out_l;
   logic       valid_m, valid_l;
`ifdef PRIORITY_EN_ONEHOT_EN
   logic [7:0] grant_m, grant_l;
`endif

   exp_t sb[$];
   int   cmp_count = 0;
   int   fail_count = 0;

   always #5 clk = ~clk;

   priority_en #(.WIDTH(8), .MSB_PRIO(1)) dut_msb (
      .clk  (clk),
      .rst  (rst_s),
      .en   (en_s),
      .in   (in_s),
`ifdef PRIORITY_EN_ONEHOT_EN
      .grant(grant_m),
`endif
      .out  (out_m),
      .valid(valid_m)
   );

   priority_en #(.WIDTH(8), .MSB_PRIO(0)) dut_lsb (
      .clk  (clk),
      .rst  (rst_s),
      .en   (en_s),
      .in   (in_s),
`ifdef PRIORITY_EN_ONEHOT_EN
      .grant(grant_l),
`endif
      .out  (out_l),
      .valid(valid_l)
   );

   // Behavioural model: scans from the priority end and stops at the first hit.
   function automatic exp_t model(input logic r, input logic e, input logic [7:0] v);
      exp_t m;
      m = '0;
      if (!r && e && v != 8'h00) begin
         m.valid_m = 1'b1;
         m.valid_l = 1'b1;
         for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
               m.out_m = 3'(i);
               break;
            end
         end
         for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
               m.out_l = 3'(i);
               break;
            end
         end
`ifdef PRIORITY_EN_ONEHOT_EN
         m.grant_m = 8'h01 << m.out_m;
         m.grant_l = 8'h01 << m.out_l;
`endif
      end
      return m;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o = '0;
      o.valid_m = valid_m;
      o.out_m   = out_m;
      o.valid_l = valid_l;
      o.out_l   = out_l;
`ifdef PRIORITY_EN_ONEHOT_EN
      o.grant_m = grant_m;
      o.grant_l = grant_l;
`endif
      return o;
   endfunction

   // Two reset edges with en=1 and all requests set, then a normal encode.
   task automatic test_reset();
      exp_t exp, obs;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rst_s = (k < 2);
         en_s  = 1'b1;
         in_s  = 8'hFF;
         sb.push_back(model(rst_s, en_s, in_s));
         @(posedge clk); #1;
         exp = sb.pop_front();
         obs = observe();
         cmp_count++;
         if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL reset[%0d]: actual=%h required=%h", k, obs, exp);
         end
      end
   endtask

   // en=0 must force zeros for every request pattern, then en=1 with no request.
   task automatic test_disable();
      exp_t exp, obs;
      for (int k = 0; k < 257; k++) begin
         @(negedge clk);
         rst_s = 1'b0;
         en_s  = (k == 256);
         in_s  = (k == 256) ? 8'h00 : 8'(k);
         sb.push_back(model(rst_s, en_s, in_s));
         @(posedge clk); #1;
         exp = sb.pop_front();
         obs = observe();
         cmp_count++;
         if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL disable[%0d]: actual=%h required=%h", k, obs, exp);
         end
      end
   endtask

   // Every 8-bit pattern twice, one edge each.
   task automatic test_sweep();
      exp_t exp, obs;
      for (int k = 0; k < 512; k++) begin
         @(negedge clk);
         rst_s = 1'b0;
         en_s  = 1'b1;
         in_s  = 8'(k);
         sb.push_back(model(rst_s, en_s, in_s));
         @(posedge clk); #1;
         exp = sb.pop_front();
         obs = observe();
         cmp_count++;
         if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL sweep[%0d]: actual=%h required=%h", k, obs, exp);
         end
      end
   endtask

   // Hand-picked MSB spot checks with literal expected indices.
   task automatic test_spot();
      logic [7:0] vec [4] = '{8'h01, 8'h80, 8'h7F, 8'h10};
      logic [2:0] idx [4] = '{3'd0, 3'd7, 3'd6, 3'd4};
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rst_s = 1'b0;
         en_s  = 1'b1;
         in_s  = vec[k];
         @(posedge clk); #1;
         cmp_count++;
         if (out_m !== idx[k] || valid_m !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL spot_msb[%0d]: actual out=%0d valid=%b required out=%0d valid=1",
                     k, out_m, valid_m, idx[k]);
         end
      end
   endtask

   // LSB-priority instance with literal expected indices.
   task automatic test_lsb();
      logic [7:0] vec [3] = '{8'hA0, 8'h81, 8'h80};
      logic [2:0] idx [3] = '{3'd5, 3'd0, 3'd7};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rst_s = 1'b0;
         en_s  = 1'b1;
         in_s  = vec[k];
         @(posedge clk); #1;
         cmp_count++;
         if (out_l !== idx[k] || valid_l !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL lsb[%0d]: actual out=%0d valid=%b required out=%0d valid=1",
                     k, out_l, valid_l, idx[k]);
         end
      end
   endtask

   // Consecutive edges, first clean, then with reset asserted on the 2nd edge.
   task automatic test_back_to_back();
      exp_t exp, obs;
      logic [7:0] vec [3] = '{8'h01, 8'h02, 8'h04};
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst_s = (pass == 1) && (k == 1);
            en_s  = 1'b1;
            in_s  = vec[k];
            sb.push_back(model(rst_s, en_s, in_s));
            @(posedge clk); #1;
            exp = sb.pop_front();
            obs = observe();
            cmp_count++;
            if (obs !== exp) begin
               fail_count++;
               $display("[TB] FAIL b2b[%0d.%0d]: actual=%h required=%h", pass, k, obs, exp);
            end
         end
      end
   endtask

   // 8'h6C: MSB winner 6 (grant 8'h40), then an idle request clears grant.
   task automatic test_onehot();
      exp_t exp, obs;
      logic [7:0] vec [2] = '{8'h6C, 8'h00};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         rst_s = 1'b0;
         en_s  = 1'b1;
         in_s  = vec[k];
         sb.push_back(model(rst_s, en_s, in_s));
         @(posedge clk); #1;
         exp = sb.pop_front();
         obs = observe();
         cmp_count++;
         if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL onehot[%0d]: actual=%h required=%h", k, obs, exp);
         end
      end
`ifdef PRIORITY_EN_ONEHOT_EN
      @(negedge clk);
      in_s = 8'h6C;
      @(posedge clk); #1;
      cmp_count++;
      if (grant_m !== 8'h40 || out_m !== 3'd6) begin
         fail_count++;
         $display("[TB] FAIL onehot_lit: actual grant=%h out=%0d required grant=40 out=6",
                  grant_m, out_m);
      end
`endif
   endtask

   initial begin
      $display("[TB] starting priority_en bench");
      test_reset();
      test_disable();
      test_sweep();
      test_spot();
      test_lsb();
      test_back_to_back();
      test_onehot();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
      $finish;
   end

endmodule

// File: doc/priority_en.md
Name: priority_en

Overview:
- Registered WIDTH-input priority encoder with enable.
- Each clock, it samples the request vector `in` and returns the index of the highest-priority set bit on `out`, plus a `valid` flag.
- Used as a small arbitration/index front-end wherever a one-cycle-latency encoded request index is needed.
- Default configuration is 8 inputs to a 3-bit index, MSB highest priority.

Parameters:
- WIDTH, 8, number of request inputs; legal range 2..64.
- OUT_W, $clog2(WIDTH), width of the encoded index; derived, not overridden by users.
- MSB_PRIO, 1, priority direction:
  - 1: bit WIDTH-1 has highest priority.
  - 0: bit 0 has highest priority.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, encoder enable; sampled on the clk edge.
- in, input, WIDTH, request vector; sampled on the clk edge.
- out, output, OUT_W, registered index of the winning request bit.
- valid, output, 1, registered flag: `out` holds a real winner.

Behaviour:
- All outputs are registered; latency is exactly 1 cycle from sampling `en`/`in` to `out`/`valid` update.
- No combinational path from inputs to outputs.
- Reset: when rst=1 at a rising edge, out<=0 and valid<=0. Reset has priority over en.
- en=0 at an edge: out<=0, valid<=0, regardless of `in`.
- en=1 and in==0: out<=0, valid<=0.
- en=1, MSB_PRIO=1, in!=0: out<=index of highest set bit, valid<=1.
  - Example, WIDTH=8: in=8'b0010_1100 -> out=5.
- en=1, MSB_PRIO=0, in!=0: out<=index of lowest set bit, valid<=1.
  - Same example -> out=2.
- Lower-priority set bits are ignored entirely; any pattern of lower bits gives the same `out`.
- If WIDTH is not a power of two, `out` never exceeds WIDTH-1.
- `out` is 0 both for "bit 0 wins" and "no request"; consumers use `valid` to distinguish the two.
- Outputs hold their last value only through reset or a new edge. Every non-reset edge reloads them from the current inputs; there is no hold-on-idle.
- Reset asserted mid-stream clears outputs at that edge. The first edge after rst deasserts produces a normal encode.

Optional Feature:
- Macro: PRIORITY_EN_ONEHOT_EN.
- Defined:
  - Adds output port `grant` [WIDTH-1:0], registered alongside `out`.
  - `grant` is the one-hot mask of the winning bit (1<<out) when valid=1, else all zeros.
  - Reset value of `grant` is 0.
  - en=0 or in==0 forces grant<=0 at the edge.
- Not defined: the `grant` port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, in=8'hFF -> out=0, valid=0 at both edges. After release, the next edge gives out=7, valid=1.
- Disable: en=0, in swept 0..255 -> out=0, valid=0 every cycle. Then en=1, in=8'h00 -> out=0, valid=0.
- Exhaustive sweep, en=1, MSB_PRIO=1: in = i[7:0] for i=0..511, one edge each (the 8-bit value wraps at 256).
  - Each cycle, out == floor(log2(in)) and valid == (in!=0), one cycle later.
  - Spot checks: in=8'h01 -> 0; 8'h80 -> 7; 8'h7F -> 6; 8'h10 -> 4.
- LSB priority (MSB_PRIO=0): in=8'hA0 -> out=5; in=8'h81 -> out=0, valid=1; in=8'h80 -> out=7.
- Latency/back-to-back: in=8'h01, 8'h02, 8'h04 on consecutive edges with en=1 -> out=0, 1, 2 on the following consecutive edges. Asserting rst on the 2nd edge -> out=0, valid=0 there, then 2.
- With PRIORITY_EN_ONEHOT_EN: in=8'h6C, en=1 -> out=6, grant=8'h40. in=8'h00 -> grant=8'h00, valid=0.
